pipelined_chunk_adder: RTL

//  Multi-cycle packet adder: accepts one packet, adds or subtracts its two WIDTH-bit operands CHUNK bits per clock, and returns the result with carry, overflow and tag.
//  A ripple carry register is kept between chunks.

---
 rtl/adder_pkg.sv | 31 +++
 rtl/pipelined_chunk_adder_chunk.sv | 51 +++++
 rtl/pipelined_chunk_adder.sv | 108 ++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// +-------------------------------------------------------------------------+
// | adder_pkg : shared FSM encoding and packet field offsets                 |
// | rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
`default_nettype none

package adder_pkg;

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_BUSY = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  // Position of the SUB flag inside the header field
  localparam int c_SUB_BIT = 0;

  // Packet is {hdr, A, B, tag} with tag at the LSB end
  function automatic int b_lsb(input int tag_w);
    return tag_w;
  endfunction

  function automatic int a_lsb(input int width, input int tag_w);
    return tag_w + width;
  endfunction

  function automatic int hdr_lsb(input int width, input int tag_w);
    return tag_w + 2 * width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipelined_chunk_adder_chunk.sv
// +-------------------------------------------------------------------------+
// | chunk_adder : CHUNK-bit ripple chain of fulladder cells                  |
// | rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
`default_nettype none

module fulladder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module chunk_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] w_c;

  assign w_c[0] = cin;

  generate
    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
      fulladder u_fa (
        .a  (a[i]),
        .b  (b[i]),
        .ci (w_c[i]),
        .s  (sum[i]),
        .co (w_c[i+1])
      );
    end
  endgenerate

  assign cout  = w_c[CHUNK];
  // Carry into the top bit of this chunk; only meaningful on the last chunk
  assign c_msb = w_c[CHUNK-1];

endmodule

`default_nettype wire

// File: rtl/pipelined_chunk_adder.sv
// +-------------------------------------------------------------------------+
// | pipelined_chunk_adder : multi-cycle add/sub, CHUNK bits per clock        |
// | rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
`default_nettype none

module pipelined_chunk_adder #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 8,
  parameter int HDR_W = 16,
  parameter int TAG_W = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [HDR_W+2*WIDTH+TAG_W-1:0] in_packet,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_sum,
  output logic                          out_co,
  output logic                          out_ovf,
  output logic [TAG_W-1:0]              out_tag,
  output logic                          busy
);
  import adder_pkg::*;

  localparam int NCHUNK    = WIDTH / CHUNK;
  localparam int IDX_W     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int c_B_LSB   = b_lsb(TAG_W);
  localparam int c_A_LSB   = a_lsb(WIDTH, TAG_W);
  localparam int c_HDR_LSB = hdr_lsb(WIDTH, TAG_W);
  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NCHUNK - 1);

  logic [1:0]             r_state;
  logic [WIDTH-1:0]       r_a;
  logic [WIDTH-1:0]       r_b;
  logic [WIDTH-1:0]       r_acc;
  logic                   r_carry;
  logic [IDX_W-1:0]       r_idx;
  logic [TAG_W-1:0]       r_tag;

  logic                   w_sub;
  logic                   w_accept;
  logic                   w_last;
  logic [CHUNK-1:0]       w_csum;
  logic                   w_cout;
  logic                   w_cmsb;
  logic [WIDTH+CHUNK-1:0] w_cat;
  logic [WIDTH-1:0]       w_acc_next;

  assign w_sub     = in_packet[c_HDR_LSB + c_SUB_BIT];
  assign in_ready  = (r_state == c_IDLE) | ((r_state == c_DONE) & out_ready);
  assign w_accept  = in_valid & in_ready;
  assign out_valid = (r_state == c_DONE);
  assign busy      = (r_state == c_BUSY);
  assign w_last    = (r_idx == c_LAST_IDX);

  // Operands shift down one chunk per cycle; sum chunks shift in from the top
  assign w_cat      = {w_csum, r_acc};
  assign w_acc_next = w_cat[WIDTH+CHUNK-1:CHUNK];

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .a     (r_a[CHUNK-1:0]),
    .b     (r_b[CHUNK-1:0]),
    .cin   (r_carry),
    .sum   (w_csum),
    .cout  (w_cout),
    .c_msb (w_cmsb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_idx   <= '0;
      out_sum <= '0;
      out_co  <= 1'b0;
      out_ovf <= 1'b0;
      out_tag <= '0;
    end else if (w_accept) begin
      r_a     <= in_packet[c_A_LSB +: WIDTH];
      r_b     <= w_sub ? ~in_packet[c_B_LSB +: WIDTH] : in_packet[c_B_LSB +: WIDTH];
      r_carry <= w_sub;
      r_tag   <= in_packet[TAG_W-1:0];
      r_idx   <= '0;
      r_state <= c_BUSY;
    end else if (r_state == c_BUSY) begin
      r_a     <= r_a >> CHUNK;
      r_b     <= r_b >> CHUNK;
      r_acc   <= w_acc_next;
      r_carry <= w_cout;
      r_idx   <= r_idx + IDX_W'(1);
      if (w_last) begin
        out_sum <= w_acc_next;
        out_co  <= w_cout;
        out_ovf <= w_cmsb ^ w_cout;
        out_tag <= r_tag;
        r_state <= c_DONE;
      end
    end else if ((r_state != c_DONE) || out_ready) begin
      // Also recovers from the unused encoding
      r_state <= c_IDLE;
    end
  end

endmodule

`default_nettype wire
